// File: rtl/skeleton_ram_bist_if.sv
// rtl/skeleton_ram_bist_if.sv - host bus of the multi-bank RAM BIST skeleton
interface skeleton_ram_bist_if #(
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_HEAD = 26,
    parameter int BITWIDTH_ADR  = 6,
    parameter int NUM_BANKS     = 2
);
    localparam int BW_BANK = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic                     EN;
    logic                     TRGG_START_CALC;
    logic                     RnW;
    logic [BW_BANK-1:0]       BANK_SEL;
    logic [BITWIDTH_ADR-1:0]  ADR;
    logic [BITWIDTH_SYS-1:0]  DATA_IN;
    logic [BITWIDTH_SYS-1:0]  DATA_OUT;
    logic [BITWIDTH_HEAD-1:0] DATA_HEAD;
    logic                     RDY;

    modport master (
        output EN, TRGG_START_CALC, RnW, BANK_SEL, ADR, DATA_IN,
        input  DATA_OUT, DATA_HEAD, RDY
    );

    modport slave (
        input  EN, TRGG_START_CALC, RnW, BANK_SEL, ADR, DATA_IN,
        output DATA_OUT, DATA_HEAD, RDY
    );
endinterface

// File: rtl/skeleton_ram_bist.sv
// rtl/skeleton_ram_bist.sv - multi-bank RAM skeleton with pattern fill/check BIST sequencer
module skeleton_ram_bist #(
    parameter int BITWIDTH_IN   = 12,
    parameter int BITWIDTH_SYS  = 16,
    parameter int BITWIDTH_HEAD = 26,
    parameter int BITWIDTH_ADR  = 6,
    parameter int NUM_BANKS     = 2
) (
    input logic                CLK_SYS,
    input logic                RSTN,
    skeleton_ram_bist_if.slave bus
);
    localparam int P       = 2**BITWIDTH_ADR - 4;
    localparam int BW_BANK = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_CHECK, S_FILL_INV, S_CHECK_INV
    } state_t;

    state_t state, state_nxt;

    logic [BITWIDTH_IN-1:0]  mem [NUM_BANKS][P];
    logic [BITWIDTH_IN-1:0]  rd_q;

    logic                    trig_q;
    logic                    mode_chk;
    logic                    start;
    logic [BW_BANK-1:0]      bank_cnt;
    logic [BITWIDTH_ADR-1:0] adr_cnt;
    logic                    drain;
    logic                    last_pos;

    logic                    cmp_valid;
    logic                    cmp_inv;
    logic [BW_BANK-1:0]      cmp_bank;
    logic [BITWIDTH_ADR-1:0] cmp_adr;
    logic                    mismatch;

    logic [BITWIDTH_SYS-1:0] err_cnt;
    logic                    err_flag;
    logic                    done;
    logic [BW_BANK-1:0]      fail_bank;
    logic [BITWIDTH_ADR-1:0] fail_adr;

    logic rdy, bist_we, bist_re, bist_inv, bist_end;
    logic host_we, host_re, adr_ok, bank_ok;
    logic [BITWIDTH_SYS-1:0] status_word;

    function automatic logic [BITWIDTH_IN-1:0] pattern(input logic [BW_BANK-1:0] b,
                                                       input logic [BITWIDTH_ADR-1:0] a,
                                                       input logic inv);
        logic [BITWIDTH_IN-1:0] p;
        p = BITWIDTH_IN'(32'(b) * 32'(P) + 32'(a));
        return inv ? ~p : p;
    endfunction

    // P is a multiple of 4, so the status window is exactly the addresses with all upper bits set
    assign adr_ok = ~&bus.ADR[BITWIDTH_ADR-1:2];

    if ((1 << BW_BANK) > NUM_BANKS) begin : g_bank_chk
        assign bank_ok = (bus.BANK_SEL < BW_BANK'(NUM_BANKS));
    end else begin : g_bank_all
        assign bank_ok = 1'b1;
    end

    if (BITWIDTH_SYS > BITWIDTH_IN) begin : g_unused_lsbs
        logic unused_data_lsbs;
        assign unused_data_lsbs = ^bus.DATA_IN[BITWIDTH_SYS-BITWIDTH_IN-1:0];
    end

    assign start    = bus.EN && bus.TRGG_START_CALC && !trig_q && (state == S_IDLE);
    assign last_pos = (bank_cnt == BW_BANK'(NUM_BANKS - 1)) && (adr_cnt == BITWIDTH_ADR'(P - 1));
    assign mismatch = cmp_valid && (rd_q != pattern(cmp_bank, cmp_adr, cmp_inv));

    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (start)    state_nxt = bus.RnW ? S_CHECK : S_FILL;
            S_FILL:      if (last_pos) state_nxt = S_CHECK;
            S_CHECK:     if (drain)    state_nxt = mode_chk ? S_IDLE : S_FILL_INV;
            S_FILL_INV:  if (last_pos) state_nxt = S_CHECK_INV;
            S_CHECK_INV: if (drain)    state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rdy      = (state == S_IDLE);
        bist_we  = (state == S_FILL) || (state == S_FILL_INV);
        bist_re  = ((state == S_CHECK) || (state == S_CHECK_INV)) && !drain;
        bist_inv = (state == S_FILL_INV) || (state == S_CHECK_INV);
        bist_end = drain && ((state == S_CHECK_INV) || ((state == S_CHECK) && mode_chk));
        host_we  = bus.EN && rdy && !start && !bus.RnW && adr_ok && bank_ok;
        host_re  = bus.EN && rdy && !start && bus.RnW;
    end

    always_comb begin
        status_word = '0;
        unique case (bus.ADR[1:0])
            2'd0:    status_word = err_cnt;
            2'd1:    status_word = BITWIDTH_SYS'({done, err_flag, !rdy});
            2'd2:    status_word = BITWIDTH_SYS'({fail_bank, fail_adr});
            default: status_word = '0;
        endcase
    end

    // Memory contents survive reset, so the array has no reset branch
    always_ff @(posedge CLK_SYS) begin
        if (bist_we)
            mem[bank_cnt][adr_cnt] <= pattern(bank_cnt, adr_cnt, bist_inv);
        else if (host_we)
            mem[bus.BANK_SEL][bus.ADR] <= bus.DATA_IN[BITWIDTH_SYS-1 -: BITWIDTH_IN];
        if (bist_re)
            rd_q <= mem[bank_cnt][adr_cnt];
    end

    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            bus.DATA_OUT <= '0;
        end else if (host_re) begin
            if (!adr_ok)
                bus.DATA_OUT <= status_word;
            else if (bank_ok)
                bus.DATA_OUT <= BITWIDTH_SYS'(mem[bus.BANK_SEL][bus.ADR]) << (BITWIDTH_SYS - BITWIDTH_IN);
            else
                bus.DATA_OUT <= '0;
        end
    end

    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            trig_q    <= 1'b0;
            mode_chk  <= 1'b0;
            bank_cnt  <= '0;
            adr_cnt   <= '0;
            drain     <= 1'b0;
            cmp_valid <= 1'b0;
            cmp_inv   <= 1'b0;
            cmp_bank  <= '0;
            cmp_adr   <= '0;
        end else begin
            trig_q    <= bus.TRGG_START_CALC;
            cmp_valid <= bist_re;
            cmp_inv   <= bist_inv;
            cmp_bank  <= bank_cnt;
            cmp_adr   <= adr_cnt;
            if (start) begin
                mode_chk <= bus.RnW;
                bank_cnt <= '0;
                adr_cnt  <= '0;
                drain    <= 1'b0;
            end else if (bist_we || bist_re) begin
                if (adr_cnt == BITWIDTH_ADR'(P - 1)) begin
                    adr_cnt <= '0;
                    if (bank_cnt == BW_BANK'(NUM_BANKS - 1)) begin
                        bank_cnt <= '0;
                        drain    <= bist_re;
                    end else begin
                        bank_cnt <= bank_cnt + BW_BANK'(1);
                    end
                end else begin
                    adr_cnt <= adr_cnt + BITWIDTH_ADR'(1);
                end
            end else begin
                drain <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            err_cnt   <= '0;
            err_flag  <= 1'b0;
            done      <= 1'b0;
            fail_bank <= '0;
            fail_adr  <= '0;
        end else if (start) begin
            err_cnt   <= '0;
            done      <= 1'b0;
            fail_bank <= '0;
            fail_adr  <= '0;
        end else begin
            if (mismatch) begin
                if (err_cnt != '1) err_cnt <= err_cnt + BITWIDTH_SYS'(1);
                err_flag  <= 1'b1;
                fail_bank <= cmp_bank;
                fail_adr  <= cmp_adr;
            end
            if (bist_end) done <= 1'b1;
        end
    end

    assign bus.RDY       = rdy;
    assign bus.DATA_HEAD = BITWIDTH_HEAD'({4'd3, 6'(P), 6'(NUM_BANKS), 5'(BITWIDTH_IN), 5'(BITWIDTH_IN)});
endmodule

// File: tb/tb_skeleton_ram_bist.sv
// tb/tb_skeleton_ram_bist.sv - self-checking bench for skeleton_ram_bist
module tb_skeleton_ram_bist;
    localparam int P = 60;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    skeleton_ram_bist_if #(.BITWIDTH_SYS(16), .BITWIDTH_HEAD(26), .BITWIDTH_ADR(6), .NUM_BANKS(2)) bus ();

    skeleton_ram_bist #(
        .BITWIDTH_IN(12), .BITWIDTH_SYS(16), .BITWIDTH_HEAD(26), .BITWIDTH_ADR(6), .NUM_BANKS(2)
    ) dut (
        .CLK_SYS(clk),
        .RSTN(rstn),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.EN = 1'b0; bus.TRGG_START_CALC = 1'b0; bus.RnW = 1'b1;
        bus.BANK_SEL = '0; bus.ADR = '0; bus.DATA_IN = '0;
    endtask

    task automatic host_write(input logic bank, input logic [5:0] adr, input logic [15:0] data);
        bus.EN = 1'b1; bus.RnW = 1'b0; bus.BANK_SEL = bank; bus.ADR = adr; bus.DATA_IN = data;
        @(negedge clk);
        bus.EN = 1'b0;
    endtask

    task automatic host_read(input logic bank, input logic [5:0] adr, input logic [15:0] exp, input string tag);
        bus.EN = 1'b1; bus.RnW = 1'b1; bus.BANK_SEL = bank; bus.ADR = adr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        bus.EN = 1'b0;
        if (exp_q.size() == 0) check("scoreboard_empty", 32'd0, 32'd1);
        else check(tag_q.pop_front(), 32'(bus.DATA_OUT), 32'(exp_q.pop_front()));
    endtask

    task automatic start_bist(input logic chk);
        bus.EN = 1'b1; bus.TRGG_START_CALC = 1'b1; bus.RnW = chk; bus.BANK_SEL = '0; bus.ADR = '0;
        @(negedge clk);
        bus.EN = 1'b0; bus.TRGG_START_CALC = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.RDY !== 1'b1 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int falls;
        logic prev;

        idle_inputs();
        repeat (3) @(negedge clk);
        check("reset_data_out", 32'(bus.DATA_OUT), 32'h0);
        check("reset_rdy", 32'(bus.RDY), 32'h1);
        check("data_head", 32'(bus.DATA_HEAD), 32'({4'd3, 6'd60, 6'd2, 5'd12, 5'd12}));
        rstn = 1'b1;
        @(negedge clk);

        host_write(1'b1, 6'd5, 16'hABC7);
        host_read(1'b1, 6'd5, 16'hABC0, "rd_b1_a5");
        host_write(1'b0, 6'd5, 16'h1234);
        host_read(1'b0, 6'd5, 16'h1230, "rd_b0_a5");
        host_read(1'b1, 6'd5, 16'hABC0, "rd_b1_a5_kept");
        host_write(1'b0, 6'd61, 16'hFFFF);
        host_read(1'b0, 6'd61, 16'h0000, "status1_after_adr61");
        host_read(1'b0, 6'd60, 16'h0000, "status0_idle");
        host_read(1'b0, 6'd63, 16'h0000, "status3");

        start_bist(1'b0);
        check("full_busy", 32'(bus.RDY), 32'h0);
        wait_idle(n);
        check("full_rdy_low_cycles", 32'(n), 32'd482);
        host_read(1'b0, 6'd60, 16'h0000, "full_err_count");
        host_read(1'b0, 6'd61, 16'h0004, "full_flags");
        host_read(1'b1, 6'd3, 16'hFC00, "full_b1_a3");
        host_read(1'b0, 6'd0, 16'hFFF0, "full_b0_a0");
        host_read(1'b0, 6'd59, 16'hFC40, "full_b0_a59");

        start_bist(1'b1);
        check("chk_busy", 32'(bus.RDY), 32'h0);
        wait_idle(n);
        check("chk_rdy_low_cycles", 32'(n), 32'd121);
        host_read(1'b0, 6'd60, 16'd120, "chk_err_count");
        host_read(1'b0, 6'd61, 16'h0006, "chk_flags");
        host_read(1'b0, 6'd62, 16'h007B, "chk_last_fail");

        start_bist(1'b1);
        check("start_drops_read", 32'(bus.DATA_OUT), 32'h007B);
        repeat (10) @(negedge clk);
        host_write(1'b0, 6'd0, 16'h5550);
        bus.EN = 1'b1; bus.RnW = 1'b1; bus.BANK_SEL = 1'b0; bus.ADR = 6'd5;
        @(negedge clk);
        bus.EN = 1'b0;
        check("busy_read_ignored", 32'(bus.DATA_OUT), 32'h007B);
        wait_idle(n);
        check("busy_run_ends", 32'(bus.RDY), 32'h1);
        host_read(1'b0, 6'd0, 16'hFFF0, "busy_write_ignored");
        host_read(1'b0, 6'd60, 16'd120, "busy_run_err_count");

        start_bist(1'b0);
        repeat (99) @(negedge clk);
        check("mid_bist_busy", 32'(bus.RDY), 32'h0);
        rstn = 1'b0;
        #1;
        check("mid_reset_rdy", 32'(bus.RDY), 32'h1);
        check("mid_reset_data_out", 32'(bus.DATA_OUT), 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        host_read(1'b0, 6'd61, 16'h0000, "mid_reset_flags");
        host_read(1'b0, 6'd60, 16'h0000, "mid_reset_err_count");
        start_bist(1'b0);
        wait_idle(n);
        check("rerun_rdy_low_cycles", 32'(n), 32'd482);
        host_read(1'b0, 6'd60, 16'h0000, "rerun_err_count");
        host_read(1'b0, 6'd61, 16'h0004, "rerun_flags");

        bus.EN = 1'b1; bus.RnW = 1'b1; bus.BANK_SEL = '0; bus.ADR = '0; bus.TRGG_START_CALC = 1'b1;
        falls = 0;
        prev = bus.RDY;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (prev && !bus.RDY) falls++;
            prev = bus.RDY;
        end
        bus.EN = 1'b0; bus.TRGG_START_CALC = 1'b0;
        @(negedge clk);
        check("hold_single_bist", 32'(falls), 32'd1);
        check("hold_idle_after", 32'(bus.RDY), 32'h1);
        host_read(1'b0, 6'd60, 16'd120, "hold_err_count");

        bus.EN = 1'b1; bus.TRGG_START_CALC = 1'b1; bus.RnW = 1'b0;
        bus.BANK_SEL = 1'b1; bus.ADR = 6'd50; bus.DATA_IN = 16'h1234;
        @(negedge clk);
        bus.EN = 1'b0; bus.TRGG_START_CALC = 1'b0;
        check("start_with_write_busy", 32'(bus.RDY), 32'h0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        host_read(1'b1, 6'd50, 16'hF910, "start_drops_write");

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
